// File: rtl/traffic_light_ctrl.sv
// Main/side intersection sequencer with pedestrian walk phase.
// Dwell times are whole seconds built from a prescaler and a seconds counter.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   MAIN_G   | main green, side red, base interval
//   MAIN_EXT | main green extended for side-street traffic
//   MAIN_Y   | main yellow, side red
//   WALK     | both heads red, walk lamp on
//   SIDE_G   | side green, main red, base interval
//   SIDE_EXT | side green extended for waiting traffic
//   SIDE_Y   | side yellow, main red
module traffic_light_ctrl #(
   parameter int TICKS_PER_SEC = 100_000_000,
   parameter int T_BASE        = 6,
   parameter int T_EXT         = 3,
   parameter int T_YEL         = 2,
   parameter int T_WALK        = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       WalkEn,
   input  logic       Sensor,
   output logic [2:0] MainLight,
   output logic [2:0] SideLight,
   output logic       WalkLamp,
   output logic [2:0] StateOut
);

   localparam int T_MAX_A = (T_BASE > T_EXT) ? T_BASE : T_EXT;
   localparam int T_MAX_B = (T_YEL > T_WALK) ? T_YEL : T_WALK;
   localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int PRE_W   = $clog2(TICKS_PER_SEC);
   localparam int SEC_W   = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {
      MAIN_G   = 3'd0,
      MAIN_EXT = 3'd1,
      MAIN_Y   = 3'd2,
      WALK     = 3'd3,
      SIDE_G   = 3'd4,
      SIDE_EXT = 3'd5,
      SIDE_Y   = 3'd6
   } state_t;

   // Kept as a plain vector so the unused encoding 7 is representable and recoverable.
   logic [2:0]       state_q;
   state_t           next_state;
   logic [PRE_W-1:0] presc_q;
   logic [SEC_W-1:0] sec_q;
   logic [SEC_W-1:0] dwell;
   logic             walk_req_q;
   logic             sec_tick;
   logic             expire;
   logic             walk_hit;
   logic             change;

   always_comb begin
      dwell = SEC_W'(T_BASE);
      case (state_q)
         MAIN_EXT, SIDE_EXT: dwell = SEC_W'(T_EXT);
         MAIN_Y, SIDE_Y:     dwell = SEC_W'(T_YEL);
         WALK:               dwell = SEC_W'(T_WALK);
         default:            dwell = SEC_W'(T_BASE);
      endcase
   end

   assign sec_tick = (presc_q == PRE_W'(TICKS_PER_SEC - 1));
   assign expire   = sec_tick && (sec_q == dwell - SEC_W'(1));
   // A press landing in MAIN_Y's last cycle is honoured in that same cycle.
   assign walk_hit = walk_req_q || WalkEn;

   always_comb begin
      next_state = MAIN_G;
      case (state_q)
         MAIN_G:   next_state = !expire ? MAIN_G   : (Sensor ? MAIN_EXT : MAIN_Y);
         MAIN_EXT: next_state = !expire ? MAIN_EXT : MAIN_Y;
         MAIN_Y:   next_state = !expire ? MAIN_Y   : (walk_hit ? WALK : SIDE_G);
         WALK:     next_state = !expire ? WALK     : SIDE_G;
         SIDE_G:   next_state = !expire ? SIDE_G   : (Sensor ? SIDE_EXT : SIDE_Y);
         SIDE_EXT: next_state = !expire ? SIDE_EXT : SIDE_Y;
         SIDE_Y:   next_state = !expire ? SIDE_Y   : MAIN_G;
         default:  next_state = MAIN_G;
      endcase
   end

   assign change = (state_q != next_state);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= MAIN_G;
         presc_q    <= '0;
         sec_q      <= '0;
         walk_req_q <= 1'b0;
      end else begin
         state_q <= next_state;
         if (change) begin
            presc_q <= '0;
            sec_q   <= '0;
         end else if (sec_tick) begin
            presc_q <= '0;
            sec_q   <= sec_q + SEC_W'(1);
         end else begin
            presc_q <= presc_q + PRE_W'(1);
         end
         if (change && next_state == WALK)
            walk_req_q <= 1'b0;
         else if (WalkEn && state_q != WALK)
            walk_req_q <= 1'b1;
      end
   end

   always_comb begin
      MainLight = 3'b100;
      SideLight = 3'b100;
      WalkLamp  = 1'b0;
      case (state_q)
         MAIN_G, MAIN_EXT: MainLight = 3'b001;
         MAIN_Y:           MainLight = 3'b010;
         WALK:             WalkLamp  = 1'b1;
         SIDE_G, SIDE_EXT: SideLight = 3'b001;
         SIDE_Y:           SideLight = 3'b010;
         default: ;
      endcase
   end

   assign StateOut = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: scenario tasks plus a cycle-level reference
// model that tracks state, time spent in it and the pending walk request.
module tb_traffic_light_ctrl;
   localparam int TPS = 4;
   localparam int TB_BASE = 6, TB_EXT = 3, TB_YEL = 2, TB_WALK = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       WalkEn = 1'b0;
   logic       Sensor = 1'b0;
   logic [2:0] MainLight, SideLight, StateOut;
   logic       WalkLamp;

   traffic_light_ctrl #(
      .TICKS_PER_SEC(TPS), .T_BASE(TB_BASE), .T_EXT(TB_EXT), .T_YEL(TB_YEL), .T_WALK(TB_WALK)
   ) dut (
      .clk(clk), .rst(rst), .WalkEn(WalkEn), .Sensor(Sensor),
      .MainLight(MainLight), .SideLight(SideLight), .WalkLamp(WalkLamp), .StateOut(StateOut)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int m_state = 0;
   int m_elapsed = 0;
   bit m_req = 1'b0;
   int log_s[$];
   int log_d[$];

   function automatic int dur(input int s);
      case (s)
         1, 5:    return TB_EXT * TPS;
         2, 6:    return TB_YEL * TPS;
         3:       return TB_WALK * TPS;
         default: return TB_BASE * TPS;
      endcase
   endfunction

   function automatic logic [2:0] exp_main(input int s);
      if (s == 0 || s == 1) return 3'b001;
      if (s == 2) return 3'b010;
      return 3'b100;
   endfunction

   function automatic logic [2:0] exp_side(input int s);
      if (s == 4 || s == 5) return 3'b001;
      if (s == 6) return 3'b010;
      return 3'b100;
   endfunction

   function automatic logic exp_walk(input int s);
      return (s == 3);
   endfunction

   task automatic clear_log();
      log_s.delete();
      log_d.delete();
   endtask

   task automatic record();
      if (log_s.size() == 0 || log_s[log_s.size()-1] != int'(StateOut)) begin
         log_s.push_back(int'(StateOut));
         log_d.push_back(1);
      end else begin
         log_d[log_d.size()-1] = log_d[log_d.size()-1] + 1;
      end
   endtask

   // Advances one clock with the given inputs and steps the reference model.
   task automatic tick(input bit w, input bit s);
      int nxt;
      bit req_eff;
      WalkEn  = w;
      Sensor  = s;
      req_eff = m_req || (w && m_state != 3);
      nxt     = m_state;
      if (m_state > 6) nxt = 0;
      else if (m_elapsed == dur(m_state) - 1) begin
         case (m_state)
            0: nxt = s ? 1 : 2;
            1: nxt = 2;
            2: nxt = req_eff ? 3 : 4;
            3: nxt = 4;
            4: nxt = s ? 5 : 6;
            5: nxt = 6;
            default: nxt = 0;
         endcase
      end
      m_req     = (nxt == 3 && m_state != 3) ? 1'b0 : req_eff;
      m_elapsed = (nxt != m_state) ? 0 : m_elapsed + 1;
      m_state   = nxt;
      @(posedge clk);
      #1;
      record();
   endtask

   task automatic do_reset(input bit w);
      rst = 1'b1; WalkEn = w; Sensor = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0; WalkEn = 1'b0;
      m_state = 0; m_elapsed = 0; m_req = 1'b0;
      clear_log();
      record();
   endtask

   task automatic test_reset();
      int cnt;
      do_reset(1'b0);
      tests++;
      if (StateOut !== 3'd0 || MainLight !== 3'b001 || SideLight !== 3'b100 || WalkLamp !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: state=%0d main=%b side=%b walk=%b, required 0 001 100 0",
                  StateOut, MainLight, SideLight, WalkLamp);
      end
      repeat (42) tick(1'b0, 1'b0);
      tests++;
      if (StateOut !== 3'd4) begin
         fails++;
         $display("FAIL reach_side_g: state=%0d, required 4", StateOut);
      end
      do_reset(1'b1);
      tests++;
      if (StateOut !== 3'd0 || MainLight !== 3'b001 || SideLight !== 3'b100 || WalkLamp !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_side_g: state=%0d main=%b side=%b walk=%b, required 0 001 100 0",
                  StateOut, MainLight, SideLight, WalkLamp);
      end
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         tick(1'b0, 1'b0);
         if (StateOut == 3'd0) cnt++;
         else break;
      end
      tests++;
      if (cnt != 24) begin
         fails++;
         $display("FAIL reset_main_g_dwell: got %0d cycles, required 24", cnt);
      end
      repeat (8) tick(1'b0, 1'b0);
      tests++;
      if (StateOut !== 3'd4) begin
         fails++;
         $display("FAIL reset_drops_walk: state=%0d, required 4", StateOut);
      end
   endtask

   task automatic test_idle();
      int exp_s[5] = '{0, 2, 4, 6, 0};
      int exp_d[5] = '{24, 8, 24, 8, 1};
      bit ok;
      do_reset(1'b0);
      for (int i = 0; i < 64; i++) begin
         tick(1'b0, 1'b0);
         tests++;
         if (StateOut !== 3'(m_state) || MainLight !== exp_main(m_state) ||
             SideLight !== exp_side(m_state) || WalkLamp !== exp_walk(m_state)) begin
            fails++;
            $display("FAIL idle_cycle: state=%0d main=%b side=%b walk=%b, required %0d %b %b %b",
                     StateOut, MainLight, SideLight, WalkLamp, m_state,
                     exp_main(m_state), exp_side(m_state), exp_walk(m_state));
         end
      end
      ok = (log_s.size() == 5);
      for (int i = 0; i < 5; i++)
         if (ok && (log_s[i] != exp_s[i] || log_d[i] != exp_d[i])) ok = 1'b0;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL idle_sequence: states %p dwells %p, required %p %p", log_s, log_d, exp_s, exp_d);
      end
   endtask

   task automatic test_sensor();
      int exp_s[7] = '{0, 1, 2, 4, 5, 6, 0};
      int exp_d[7] = '{24, 12, 8, 24, 12, 8, 1};
      bit ok;
      do_reset(1'b0);
      for (int i = 0; i < 88; i++) begin
         tick(1'b0, 1'b1);
         tests++;
         if (StateOut !== 3'(m_state) || MainLight !== exp_main(m_state) || SideLight !== exp_side(m_state)) begin
            fails++;
            $display("FAIL sensor_cycle: state=%0d main=%b side=%b, required %0d %b %b",
                     StateOut, MainLight, SideLight, m_state, exp_main(m_state), exp_side(m_state));
         end
      end
      ok = (log_s.size() == 7);
      for (int i = 0; i < 7; i++)
         if (ok && (log_s[i] != exp_s[i] || log_d[i] != exp_d[i])) ok = 1'b0;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL sensor_sequence: states %p dwells %p, required %p %p", log_s, log_d, exp_s, exp_d);
      end
      do_reset(1'b0);
      for (int i = 1; i <= 40; i++) tick(1'b0, (i >= 5 && i <= 15));
      tests++;
      if (log_s.size() < 2 || log_s[1] != 2) begin
         fails++;
         $display("FAIL sensor_mid_pulse: states %p, required MAIN_G then 2", log_s);
      end
   endtask

   task automatic test_walk();
      int exp_s[6] = '{0, 2, 3, 4, 6, 0};
      int exp_d[6] = '{24, 8, 12, 24, 8, 1};
      bit ok;
      do_reset(1'b0);
      for (int i = 1; i <= 76; i++) begin
         tick((i == 5 || i == 6), 1'b0);
         tests++;
         if (StateOut !== 3'(m_state) || MainLight !== exp_main(m_state) ||
             SideLight !== exp_side(m_state) || WalkLamp !== exp_walk(m_state)) begin
            fails++;
            $display("FAIL walk_cycle: state=%0d main=%b side=%b walk=%b, required %0d %b %b %b",
                     StateOut, MainLight, SideLight, WalkLamp, m_state,
                     exp_main(m_state), exp_side(m_state), exp_walk(m_state));
         end
      end
      ok = (log_s.size() == 6);
      for (int i = 0; i < 6; i++)
         if (ok && (log_s[i] != exp_s[i] || log_d[i] != exp_d[i])) ok = 1'b0;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL walk_sequence: states %p dwells %p, required %p %p", log_s, log_d, exp_s, exp_d);
      end
      clear_log();
      repeat (63) tick(1'b0, 1'b0);
      tests++;
      if (3 inside {log_s}) begin
         fails++;
         $display("FAIL walk_next_loop: states %p, required no state 3", log_s);
      end
   endtask

   task automatic test_walk_edges();
      bit hit;
      int walks;
      do_reset(1'b0);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (m_state == 2 && m_elapsed == dur(2) - 1) begin
            tick(1'b1, 1'b0);
            hit = 1'b1;
         end else tick(1'b0, 1'b0);
      end
      tests++;
      if (!hit || StateOut !== 3'd3) begin
         fails++;
         $display("FAIL walk_last_yellow_cycle: state=%0d reached=%0d, required 3", StateOut, hit);
      end
      for (int i = 0; i < 100 && StateOut == 3'd3; i++) tick(1'b1, 1'b0);
      clear_log();
      repeat (70) tick(1'b0, 1'b0);
      tests++;
      if (3 inside {log_s}) begin
         fails++;
         $display("FAIL walk_during_walk: states %p, required no state 3", log_s);
      end
      do_reset(1'b0);
      for (int i = 1; i <= 140; i++) tick((i == 3 || i == 10 || i == 28), 1'b0);
      walks = 0;
      foreach (log_s[i]) if (log_s[i] == 3) walks++;
      tests++;
      if (walks != 1) begin
         fails++;
         $display("FAIL walk_three_presses: got %0d walk phases, required 1", walks);
      end
   endtask

   task automatic test_illegal();
      int cnt;
      do_reset(1'b0);
      repeat (5) tick(1'b0, 1'b0);
      force dut.state_q = 3'd7;
      #1;
      release dut.state_q;
      m_state = 7;
      tick(1'b0, 1'b0);
      tests++;
      if (StateOut !== 3'd0 || MainLight !== 3'b001 || SideLight !== 3'b100) begin
         fails++;
         $display("FAIL illegal_recover: state=%0d main=%b side=%b, required 0 001 100",
                  StateOut, MainLight, SideLight);
      end
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         tick(1'b0, 1'b0);
         if (StateOut == 3'd0) cnt++;
         else break;
      end
      tests++;
      if (cnt != 24) begin
         fails++;
         $display("FAIL illegal_main_g_dwell: got %0d cycles, required 24", cnt);
      end
   endtask

   task automatic test_random();
      bit w, s;
      do_reset(1'b0);
      for (int i = 0; i < 2000; i++) begin
         w = ($urandom_range(0, 19) == 0);
         s = $urandom_range(0, 1) != 0;
         tick(w, s);
         tests++;
         if (StateOut !== 3'(m_state) || MainLight !== exp_main(m_state) ||
             SideLight !== exp_side(m_state) || WalkLamp !== exp_walk(m_state)) begin
            fails++;
            $display("FAIL random_cycle %0d: state=%0d main=%b side=%b walk=%b, required %0d %b %b %b",
                     i, StateOut, MainLight, SideLight, WalkLamp, m_state,
                     exp_main(m_state), exp_side(m_state), exp_walk(m_state));
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_sensor();
      test_walk();
      test_walk_edges();
      test_illegal();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
